xsleena_sdr_arbiter: RTL and testbench

- Five-client SDRAM read arbiter that sits directly upstream of the core's ROM fetch ports.
- Clients are main CPU, sub CPU, OBJ, BACK1 and BACK2. Each presents an sdr_*_addr/sdr_*_req pair and receives sdr_*_dout/sdr_*_rdy back.
- It serialises these requests onto one single-outstanding read port of the SDRAM controller.
- Arbitration is round-robin. Each client has an optional one-word hit buffer so that repeated fetches of the same word are returned without an SDRAM access.

---
 rtl/xsleena_sdr_arbiter.sv | 158 +++++++++++++++
 tb/tb_xsleena_sdr_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xsleena_sdr_arbiter.sv
// Five-client round-robin SDRAM read arbiter with a per-client one-word hit
// buffer. Requests are serialised onto a single-outstanding controller port.
module xsleena_sdr_arbiter #(
  parameter int NCLI     = 5,
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int CACHE_EN = 1
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               flush,
  input  logic [NCLI*AW-1:0] cli_addr,
  input  logic [NCLI-1:0]    cli_req,
  output logic [NCLI*DW-1:0] cli_dout,
  output logic [NCLI-1:0]    cli_rdy,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_rd,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_dout,
  output logic               busy
);

  localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gnt_q;
  logic [AW-1:0]     mem_addr_q;
  logic              mem_rd_q;
  logic [NCLI-1:0]   rdy_q;
  logic [NCLI-1:0]   mask_q;
  logic              flush_seen_q;
  logic [NCLI-1:0]   hitv_q;
  logic [AW-1:0]     hit_addr_q [NCLI];
  logic [DW-1:0]     dout_q     [NCLI];

  logic [AW-1:0]     addr_a [NCLI];
  logic [NCLI-1:0]   eligible;
  logic              sel_found;
  logic [PW-1:0]     sel_idx;
  logic [PW:0]       sum;
  logic [PW-1:0]     cand;
  logic              hit_now;

  // Wrap-around increment of a client index.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    if (i == PW'(NCLI - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Unpack client addresses and pack held read data.
  always_comb begin
    cli_dout = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      addr_a[i]              = cli_addr[i*AW +: AW];
      cli_dout[i*DW +: DW]   = dout_q[i];
    end
  end

  // Round-robin pick: first eligible client at or above ptr, modulo NCLI.
  always_comb begin
    eligible  = cli_req & ~mask_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NCLI; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NCLI)) begin
        sum = sum - (PW+1)'(NCLI);
      end
      cand = sum[PW-1:0];
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // A flush in the decision cycle forces the miss path.
  always_comb begin
    hit_now = (CACHE_EN != 0) && sel_found && hitv_q[sel_idx] && !flush &&
              (addr_a[sel_idx] == hit_addr_q[sel_idx]);
  end

  // Arbiter FSM with registered memory-port and client outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      rdy_q        <= '0;
      mask_q       <= '0;
      flush_seen_q <= 1'b0;
      hitv_q       <= '0;
      for (int unsigned i = 0; i < NCLI; i++) begin
        hit_addr_q[i] <= '0;
        dout_q[i]     <= '0;
      end
    end else begin
      rdy_q  <= '0;
      mask_q <= '0;
      if (flush) begin
        hitv_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            if (hit_now) begin
              rdy_q[sel_idx]  <= 1'b1;
              mask_q[sel_idx] <= 1'b1;
              ptr_q           <= nxt(sel_idx);
            end else begin
              mem_addr_q   <= addr_a[sel_idx];
              mem_rd_q     <= 1'b1;
              gnt_q        <= sel_idx;
              flush_seen_q <= 1'b0;
              state_q      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) begin
            flush_seen_q <= 1'b1;
          end
          if (mem_ack) begin
            mem_rd_q       <= 1'b0;
            dout_q[gnt_q]  <= mem_dout;
            rdy_q[gnt_q]   <= 1'b1;
            mask_q[gnt_q]  <= 1'b1;
            ptr_q          <= nxt(gnt_q);
            state_q        <= ST_IDLE;
            if ((CACHE_EN != 0) && !flush && !flush_seen_q) begin
              hitv_q[gnt_q]     <= 1'b1;
              hit_addr_q[gnt_q] <= mem_addr_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cli_rdy  = rdy_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xsleena_sdr_arbiter.sv
// Bench for xsleena_sdr_arbiter: queue-driven clients, a programmable memory
// responder, a rule-level reference model and directed literal checks.
module tb_xsleena_sdr_arbiter;

  localparam int NCLI = 5;
  localparam int AW   = 25;
  localparam int DW   = 16;

  logic               clk = 1'b0;
  logic               RSTn = 1'b0;
  logic               flush = 1'b0;
  logic [NCLI*AW-1:0] cli_addr = '0;
  logic [NCLI-1:0]    cli_req = '0;
  logic [NCLI*DW-1:0] cli_dout;
  logic [NCLI-1:0]    cli_rdy;
  logic [AW-1:0]      mem_addr;
  logic               mem_rd;
  logic               mem_ack;
  logic [DW-1:0]      mem_dout;
  logic               busy;

  logic               r_ack = 1'b0, m_ack = 1'b0;
  logic [DW-1:0]      r_dout = '0, m_dout = '0;
  assign mem_ack  = r_ack | m_ack;
  assign mem_dout = m_ack ? m_dout : r_dout;

  logic [NCLI*DW-1:0] nc_dout;
  logic [NCLI-1:0]    nc_rdy;
  logic [AW-1:0]      nc_mem_addr;
  logic               nc_mem_rd;
  logic               nc_ack = 1'b0;
  logic [DW-1:0]      nc_mdout = '0;
  logic               nc_busy;

  xsleena_sdr_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .CACHE_EN(1)) dut (
    .clk(clk), .RSTn(RSTn), .flush(flush), .cli_addr(cli_addr), .cli_req(cli_req),
    .cli_dout(cli_dout), .cli_rdy(cli_rdy), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .busy(busy));

  xsleena_sdr_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .CACHE_EN(0)) dut_nc (
    .clk(clk), .RSTn(RSTn), .flush(flush), .cli_addr(cli_addr), .cli_req(cli_req),
    .cli_dout(nc_dout), .cli_rdy(nc_rdy), .mem_addr(nc_mem_addr), .mem_rd(nc_mem_rd),
    .mem_ack(nc_ack), .mem_dout(nc_mdout), .busy(nc_busy));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Client and responder state
  logic [AW-1:0]   q [NCLI][$];
  logic [NCLI-1:0] saw_rdy = '0;
  int              rdy_log [$];
  bit              resp_en = 1'b1;
  int              ack_delay = 5;
  int              wcnt = 0, ncnt = 0;
  logic [DW-1:0]   salt = 16'h1111;

  // Reference model state (outputs expected after each rising edge)
  bit              m_busy = 1'b0;
  int              m_ptr = 0, m_cur = 0;
  bit              m_fl = 1'b0;
  bit              m_hv [NCLI];
  logic [AW-1:0]   m_ha [NCLI];
  logic [NCLI-1:0] e_rdy = '0;
  bit              e_mem_rd = 1'b0;
  logic [AW-1:0]   e_mem_addr = '0;
  logic [DW-1:0]   e_dout [NCLI];

  // Rule-level model: serve the first eligible client from ptr; a stale
  // request during its own ready cycle is not eligible.
  always @(posedge clk or negedge RSTn) begin : model
    logic [NCLI-1:0] prev;
    logic [AW-1:0]   a;
    int              g;
    if (!RSTn) begin
      m_busy = 0; m_ptr = 0; m_fl = 0; e_rdy = '0; e_mem_rd = 0; e_mem_addr = '0;
      for (int i = 0; i < NCLI; i++) begin
        m_hv[i] = 0; m_ha[i] = '0; e_dout[i] = '0;
      end
    end else begin
      prev  = e_rdy;
      e_rdy = '0;
      if (flush) for (int i = 0; i < NCLI; i++) m_hv[i] = 0;
      if (!m_busy) begin
        g = -1;
        for (int k = 0; k < NCLI; k++)
          if (g < 0 && cli_req[(m_ptr + k) % NCLI] && !prev[(m_ptr + k) % NCLI])
            g = (m_ptr + k) % NCLI;
        if (g >= 0) begin
          a = cli_addr[g*AW +: AW];
          if (m_hv[g] && !flush && m_ha[g] == a) begin
            e_rdy[g] = 1'b1;
            m_ptr    = (g + 1) % NCLI;
          end else begin
            m_busy = 1; m_cur = g; m_fl = 0; e_mem_rd = 1; e_mem_addr = a;
          end
        end
      end else if (mem_ack) begin
        e_mem_rd       = 0;
        e_dout[m_cur]  = mem_dout;
        e_rdy[m_cur]   = 1'b1;
        m_ptr          = (m_cur + 1) % NCLI;
        m_busy         = 0;
        if (!(m_fl || flush)) begin
          m_hv[m_cur] = 1; m_ha[m_cur] = e_mem_addr;
        end
      end else if (flush) begin
        m_fl = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [NCLI*DW-1:0] ed;
    for (int i = 0; i < NCLI; i++) ed[i*DW +: DW] = e_dout[i];
    chk("model mem_rd", mem_rd, e_mem_rd);
    chk("model mem_addr", mem_addr, e_mem_addr);
    chk("model busy", busy, m_busy);
    chk("model cli_rdy", cli_rdy, e_rdy);
    chk("model cli_dout", cli_dout, ed);
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] ad);
    if (ad == 25'h0012340) return 16'hBEEF;
    return ad[15:0] ^ salt;
  endfunction

  // One clock: check against the model after the rising edge, then drive
  // clients and responders on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
    cmp_model();
    @(negedge clk);
    for (int i = 0; i < NCLI; i++) begin
      if (saw_rdy[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (q[i].size() > 0) begin
        cli_req[i] = 1'b1;
        cli_addr[i*AW +: AW] = q[i][0];
      end else begin
        cli_req[i] = 1'b0;
      end
      saw_rdy[i] = cli_rdy[i];
      if (cli_rdy[i]) rdy_log.push_back(i);
    end
    r_ack = 1'b0;
    if (resp_en && mem_rd) begin
      wcnt++;
      if (wcnt == ack_delay + 1) begin
        r_ack = 1'b1; r_dout = mem_data(mem_addr); wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
    nc_ack = 1'b0;
    if (nc_mem_rd) begin
      ncnt++;
      if (ncnt == 3) begin
        nc_ack = 1'b1; nc_mdout = nc_mem_addr[15:0]; ncnt = 0;
      end
    end else begin
      ncnt = 0;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NCLI; i++) if (q[i].size() > 0) return 1'b1;
    return (cli_req != '0) || busy || nc_busy;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while (pending() && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for idle", nm);
    end
    tick();
    tick();
  endtask

  initial begin : stim
    int exp_order [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
    repeat (3) tick();
    chk("reset mem_rd", mem_rd, 1'b0);
    chk("reset mem_addr", mem_addr, 25'h0);
    chk("reset rdy", cli_rdy, 5'h0);
    chk("reset dout", cli_dout, '0);
    chk("reset busy", busy, 1'b0);
    RSTn = 1'b1;
    tick();

    // Miss path on bg1 with a 5-cycle ack delay
    ack_delay = 5;
    q[3].push_back(25'h0012340);
    tick();
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("miss mem_rd held", mem_rd, 1'b1);
      chk("miss mem_addr", mem_addr, 25'h0012340);
      chk("miss busy", busy, 1'b1);
    end
    tick();
    chk("miss rdy3", cli_rdy, 5'b01000);
    chk("miss dout3", cli_dout[3*DW +: DW], 16'hBEEF);
    chk("miss mem_rd drop", mem_rd, 1'b0);
    tick();
    chk("mask cycle no regrant", cli_rdy, 5'b00000);
    wait_idle("miss");

    // Repeat of the same word: hit on the cached instance, miss on the other
    q[3].push_back(25'h0012340);
    tick();
    chk("nc idle before repeat", nc_mem_rd, 1'b0);
    tick();
    chk("hit rdy3", cli_rdy, 5'b01000);
    chk("hit no mem_rd", mem_rd, 1'b0);
    chk("hit dout3", cli_dout[3*DW +: DW], 16'hBEEF);
    chk("nocache mem_rd", nc_mem_rd, 1'b1);
    tick();
    chk("hit single pulse", cli_rdy, 5'b00000);
    wait_idle("hit");

    // All clients at once, with 0..2 chaining a second address
    ack_delay = 2;
    q[4].push_back(25'h0000400);
    wait_idle("ptr align");
    rdy_log.delete();
    for (int i = 0; i < NCLI; i++) q[i].push_back(25'h0100000 + 25'(i * 'h100));
    for (int i = 0; i < 3; i++) q[i].push_back(25'h0200000 + 25'(i * 'h100));
    wait_idle("round robin");
    chk("rr grant count", rdy_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rdy_log.size()) chk($sformatf("rr order %0d", i), rdy_log[i], exp_order[i]);

    // Flush between identical obj requests
    ack_delay = 3;
    salt = 16'h1111;
    q[2].push_back(25'h0022220);
    wait_idle("obj miss");
    chk("obj dout first", cli_dout[2*DW +: DW], 16'h3331);
    q[2].push_back(25'h0022220);
    tick();
    tick();
    chk("obj hit rdy", cli_rdy, 5'b00100);
    chk("obj hit no mem_rd", mem_rd, 1'b0);
    wait_idle("obj hit");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    salt = 16'h00FF;
    q[2].push_back(25'h0022220);
    tick();
    tick();
    chk("post flush miss", mem_rd, 1'b1);
    chk("post flush addr", mem_addr, 25'h0022220);
    wait_idle("post flush");
    chk("obj dout relatched", cli_dout[2*DW +: DW], 16'h22DF);

    // Flush while waiting: completion must not validate the buffer
    q[2].push_back(25'h0022230);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("flush in wait");
    q[2].push_back(25'h0022230);
    tick();
    tick();
    chk("wait flush no hitv", mem_rd, 1'b1);
    wait_idle("refill");

    // Flush in the decision cycle suppresses a would-be hit
    q[2].push_back(25'h0022230);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("decision flush miss", mem_rd, 1'b1);
    chk("decision flush no rdy", cli_rdy, 5'b00000);
    wait_idle("decision flush");

    // Reset in the middle of a wait, then a late ack
    resp_en = 1'b0;
    q[0].push_back(25'h0000777);
    tick();
    tick();
    chk("pre reset mem_rd", mem_rd, 1'b1);
    RSTn = 1'b0;
    #1;
    chk("reset drops mem_rd", mem_rd, 1'b0);
    chk("reset clears busy", busy, 1'b0);
    for (int i = 0; i < NCLI; i++) q[i].delete();
    saw_rdy = '0;
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    tick();
    m_ack  = 1'b1;
    m_dout = 16'hDEAD;
    tick();
    m_ack = 1'b0;
    chk("late ack no rdy", cli_rdy, 5'b00000);
    tick();
    chk("late ack no rdy2", cli_rdy, 5'b00000);
    chk("late ack dout", cli_dout, '0);
    resp_en = 1'b1;
    q[3].push_back(25'h0012340);
    tick();
    tick();
    chk("post reset miss", mem_rd, 1'b1);
    wait_idle("post reset");
    chk("post reset dout3", cli_dout[3*DW +: DW], 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
